// File: rtl/uart_rx_byte_framer.sv
// UART receive front end: synchronises the serial line, recovers 8N1 frames by mid-bit sampling and
// holds each byte in a one-entry valid/ready register. Define UART_RX_PARITY_EN for 8E1 framing.
module uart_rx_byte_framer #(
  parameter int unsigned CLKS_PER_BIT = 234,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       rx_busy
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_RX_PARITY_EN
    StParity,
`endif
    StStop,
    StWaitIdle
  } state_e;

  state_e                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [CntW-1:0]        r_baud;
  logic [2:0]             r_bit_idx;
  logic [7:0]             r_shift;
  logic [7:0]             r_data;
  logic                   r_valid;
  logic                   r_frame_err;
  logic                   r_overrun;

  logic w_rx_s;
  logic w_baud_done;
  logic w_stop_sample;
  logic w_par_ok;
  logic w_complete;

  assign w_rx_s        = r_sync[SYNC_STAGES-1];
  assign w_baud_done   = (r_baud == '0);
  assign w_stop_sample = (r_state == StStop) && w_baud_done;

`ifdef UART_RX_PARITY_EN
  logic r_par;
  logic r_parity_err;
  assign w_par_ok   = ~(^{r_shift, r_par});
  assign parity_err = r_parity_err;
`else
  assign w_par_ok = 1'b1;
`endif

  assign w_complete = w_stop_sample && w_rx_s && w_par_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync      <= '1;
      r_state     <= StIdle;
      r_baud      <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par        <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_sync      <= {r_sync[SYNC_STAGES-2:0], uart_rx};
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err <= w_stop_sample && w_rx_s && !w_par_ok;
`endif

      case (r_state)
        StIdle: begin
          if (!w_rx_s) begin
            r_baud  <= HalfLast;
            r_state <= StStart;
          end
        end
        StStart: begin
          if (!w_baud_done) begin
            r_baud <= r_baud - CntOne;
          end else if (!w_rx_s) begin
            r_baud    <= BitLast;
            r_bit_idx <= '0;
            r_state   <= StData;
          end else begin
            // Start bit gone by mid-bit: treat as a glitch.
            r_state <= StIdle;
          end
        end
        StData: begin
          if (!w_baud_done) begin
            r_baud <= r_baud - CntOne;
          end else begin
            r_shift[r_bit_idx] <= w_rx_s;
            r_baud             <= BitLast;
            r_bit_idx          <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              r_state <= StParity;
`else
              r_state <= StStop;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        StParity: begin
          if (!w_baud_done) begin
            r_baud <= r_baud - CntOne;
          end else begin
            r_par   <= w_rx_s;
            r_baud  <= BitLast;
            r_state <= StStop;
          end
        end
`endif
        StStop: begin
          if (!w_baud_done) begin
            r_baud <= r_baud - CntOne;
          end else if (w_rx_s) begin
            r_state <= StIdle;
          end else begin
            r_frame_err <= 1'b1;
            r_state     <= StWaitIdle;
          end
        end
        StWaitIdle: begin
          if (w_rx_s) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase

      // Holding register: a same-cycle handshake frees the slot for the new byte.
      if (w_complete) begin
        if (!r_valid || rx_ready) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && rx_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_data   = r_data;
  assign rx_valid  = r_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign rx_busy   = (r_state != StIdle);

endmodule

// File: tb/tb_uart_rx_byte_framer.sv
// Directed self-checking bench for uart_rx_byte_framer at 16 clocks per bit.
module tb_uart_rx_byte_framer;

  localparam int unsigned CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int StopIdx = 10;
`else
  localparam int StopIdx = 9;
`endif
  localparam int RiseMin = StopIdx * CPB + 2;
  localparam int RiseMax = StopIdx * CPB + 18;

  logic       clk = 1'b0;
  logic       rst;
  logic       uart_rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       rx_busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
  logic       par_flip = 1'b0;
`endif

  uart_rx_byte_framer #(
    .CLKS_PER_BIT(CPB),
    .SYNC_STAGES (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .uart_rx  (uart_rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .rx_busy  (rx_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int fe_cnt   = 0;
  int ov_cnt   = 0;
  int pe_cnt   = 0;
  int both_cnt = 0;
  logic [7:0] hs_q[$];

  logic busy_prev;
  logic busy_rise;

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid && rx_ready) hs_q.push_back(rx_data);
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (frame_err && overrun) both_cnt++;
`ifdef UART_RX_PARITY_EN
      if (parity_err) pe_cnt++;
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    uart_rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      repeat (CPB) tick();
    end
`ifdef UART_RX_PARITY_EN
    uart_rx = (^d) ^ par_flip;
    repeat (CPB) tick();
`endif
    uart_rx = stop;
    repeat (CPB) tick();
  endtask

  // Sends one frame while counting edges from the falling start edge; optionally pulses
  // rx_ready during the cycle that ends at edge ready_at+1.
  task automatic send_watch(input logic [7:0] d, input logic stop, input int ready_at,
                            output int rise_at);
    int r;
    r = -1;
    busy_prev = 1'b0;
    busy_rise = 1'b0;
    fork
      send_frame(d, stop);
      begin
        logic was_valid;
        was_valid = rx_valid;
        for (int c = 1; c <= (StopIdx + 1) * CPB; c++) begin
          logic b;
          b = rx_busy;
          tick();
          if (ready_at > 0 && c == ready_at) rx_ready = 1'b1;
          else if (ready_at > 0 && c == ready_at + 1) rx_ready = 1'b0;
          if (r < 0 && !was_valid && rx_valid) begin
            r = c;
            busy_prev = b;
            busy_rise = rx_busy;
          end
        end
      end
    join
    rise_at = r;
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b1; uart_rx = 1'b1; rx_ready = 1'b0;
    repeat (3) tick();
    n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", rx_data); end
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", rx_valid); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b expected 0", frame_err); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_ovr: got %b expected 0", overrun); end
    n_checks++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", rx_busy); end
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if ({rx_data, rx_valid, frame_err, overrun, rx_busy} !== 12'h000) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL idle_stable: got %0d changed cycles expected 0", bad); end
  endtask

  task automatic test_single();
    int r, base;
    base = hs_q.size();
    rx_ready = 1'b0;
    send_watch(8'hA5, 1'b1, 0, r);
    n_checks++; if (r < RiseMin || r > RiseMax) begin n_fail++; $display("FAIL single_rise: got edge %0d expected %0d..%0d", r, RiseMin, RiseMax); end
    n_checks++; if ({busy_prev, busy_rise} !== 2'b10) begin n_fail++; $display("FAIL single_latency: got busy before/at rise %b%b expected 10", busy_prev, busy_rise); end
    n_checks++; if (rx_data !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %h expected a5", rx_data); end
    repeat (3) tick();
    n_checks++; if ({rx_valid, rx_data} !== 9'h1A5) begin n_fail++; $display("FAIL single_hold: got %b/%h expected 1/a5", rx_valid, rx_data); end
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    n_checks++; if ({rx_valid, rx_data} !== 9'h0A5) begin n_fail++; $display("FAIL single_consume: got %b/%h expected 0/a5", rx_valid, rx_data); end
    n_checks++; if (hs_q.size() != base + 1 || hs_q[hs_q.size()-1] !== 8'hA5) begin n_fail++; $display("FAIL single_hs: got %0d handshakes expected 1 of a5", hs_q.size() - base); end
  endtask

  task automatic test_back_to_back();
    int base, fe0, ov0;
    logic [7:0] exp_b[3];
    exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'h3C;
    base = hs_q.size(); fe0 = fe_cnt; ov0 = ov_cnt;
    rx_ready = 1'b1;
    for (int i = 0; i < 3; i++) send_frame(exp_b[i], 1'b1);
    repeat (20) tick();
    rx_ready = 1'b0;
    n_checks++; if (hs_q.size() != base + 3) begin n_fail++; $display("FAIL b2b_count: got %0d expected 3", hs_q.size() - base); end
    for (int i = 0; i < 3; i++) begin
      if (hs_q.size() > base + i) begin
        n_checks++;
        if (hs_q[base+i] !== exp_b[i]) begin n_fail++; $display("FAIL b2b_byte%0d: got %h expected %h", i, hs_q[base+i], exp_b[i]); end
      end
    end
    n_checks++; if (fe_cnt != fe0 || ov_cnt != ov0) begin n_fail++; $display("FAIL b2b_errs: got fe %0d ov %0d expected 0 0", fe_cnt - fe0, ov_cnt - ov0); end
  endtask

  task automatic test_glitch_framing();
    int fe0, ov0;
    logic saw_busy;
    fe0 = fe_cnt; ov0 = ov_cnt;
    saw_busy = 1'b0;
    uart_rx = 1'b0;
    for (int i = 0; i < 44; i++) begin
      if (i == 4) uart_rx = 1'b1;
      tick();
      if (rx_busy) saw_busy = 1'b1;
    end
    n_checks++; if (saw_busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_seen: got %b expected 1", saw_busy); end
    n_checks++; if ({rx_busy, rx_valid} !== 2'b00) begin n_fail++; $display("FAIL glitch_idle: got busy/valid %b%b expected 00", rx_busy, rx_valid); end
    n_checks++; if (fe_cnt != fe0 || ov_cnt != ov0) begin n_fail++; $display("FAIL glitch_flags: got fe %0d ov %0d expected 0 0", fe_cnt - fe0, ov_cnt - ov0); end
    send_frame(8'h55, 1'b0);
    repeat (200) tick();
    n_checks++; if (fe_cnt - fe0 != 1) begin n_fail++; $display("FAIL frame_err_once: got %0d expected 1", fe_cnt - fe0); end
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL frame_no_valid: got %b expected 0", rx_valid); end
    n_checks++; if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL break_busy: got %b expected 1", rx_busy); end
    uart_rx = 1'b1;
    repeat (20) tick();
    n_checks++; if (rx_busy !== 1'b0 || fe_cnt - fe0 != 1) begin n_fail++; $display("FAIL break_release: got busy %b fe %0d expected 0 1", rx_busy, fe_cnt - fe0); end
  endtask

  task automatic test_overrun();
    int ov0, fe0, base, r1, r2;
    ov0 = ov_cnt; fe0 = fe_cnt;
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    repeat (20) tick();
    n_checks++; if (ov_cnt - ov0 != 1) begin n_fail++; $display("FAIL overrun_once: got %0d expected 1", ov_cnt - ov0); end
    n_checks++; if ({rx_valid, rx_data} !== 9'h111) begin n_fail++; $display("FAIL overrun_keep: got %b/%h expected 1/11", rx_valid, rx_data); end
    n_checks++; if (fe_cnt != fe0) begin n_fail++; $display("FAIL overrun_no_ferr: got %0d expected 0", fe_cnt - fe0); end
    rx_ready = 1'b1; tick(); rx_ready = 1'b0;
    repeat (10) tick();
    ov0 = ov_cnt;
    send_watch(8'h11, 1'b1, 0, r1);
    repeat (10) tick();
    base = hs_q.size();
    send_watch(8'h22, 1'b1, (r1 > 1) ? r1 - 1 : 0, r2);
    repeat (5) tick();
    n_checks++; if ({rx_valid, rx_data} !== 9'h122) begin n_fail++; $display("FAIL same_cycle_load: got %b/%h expected 1/22", rx_valid, rx_data); end
    n_checks++; if (ov_cnt != ov0) begin n_fail++; $display("FAIL same_cycle_ovr: got %0d expected 0", ov_cnt - ov0); end
    n_checks++; if (hs_q.size() != base + 1 || hs_q[hs_q.size()-1] !== 8'h11) begin n_fail++; $display("FAIL same_cycle_hs: got %0d handshakes expected 1 of 11", hs_q.size() - base); end
    rx_ready = 1'b1; tick(); rx_ready = 1'b0;
  endtask

  task automatic test_reset_midframe();
    int r;
    rx_ready = 1'b0;
    fork
      send_frame(8'h81, 1'b1);
      begin
        repeat (5 * CPB + 8) tick();
        rst = 1'b1;
        #1;
        n_checks++; if ({rx_busy, rx_valid} !== 2'b00) begin n_fail++; $display("FAIL async_reset: got busy/valid %b%b expected 00", rx_busy, rx_valid); end
      end
    join
    rst = 1'b0;
    repeat (20) tick();
    n_checks++; if ({rx_valid, rx_busy} !== 2'b00) begin n_fail++; $display("FAIL midframe_no_byte: got valid/busy %b%b expected 00", rx_valid, rx_busy); end
    send_watch(8'h7E, 1'b1, 0, r);
    repeat (3) tick();
    n_checks++; if ({rx_valid, rx_data} !== 9'h17E) begin n_fail++; $display("FAIL after_reset_byte: got %b/%h expected 1/7e", rx_valid, rx_data); end
    rx_ready = 1'b1; tick(); rx_ready = 1'b0;
    repeat (5) tick();
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int pe0, fe0;
    pe0 = pe_cnt; fe0 = fe_cnt;
    par_flip = 1'b1;
    send_frame(8'h7E, 1'b1);
    par_flip = 1'b0;
    repeat (20) tick();
    n_checks++; if (pe_cnt - pe0 != 1) begin n_fail++; $display("FAIL parity_once: got %0d expected 1", pe_cnt - pe0); end
    n_checks++; if (rx_valid !== 1'b0 || fe_cnt != fe0) begin n_fail++; $display("FAIL parity_discard: got valid %b fe %0d expected 0 0", rx_valid, fe_cnt - fe0); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch_framing();
    test_overrun();
    test_reset_midframe();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    n_checks++; if (both_cnt != 0) begin n_fail++; $display("FAIL ferr_ovr_exclusive: got %0d cycles expected 0", both_cnt); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
